lockin_sample_fifo: RTL

- Buffers lock-in results for the processing system.
- Sits directly downstream of the lock-in amplifier: captures each x/y pair on the lock-in done strobe and tags it with a 32-bit sequence number.
- Holds samples in a first-word-fall-through FIFO until software pops them through a register-mapped read strobe, so no result is lost between processor register polls.

---
 rtl/lockin_pkg.sv | 18 +
 rtl/lockin_fifo_mem.sv | 33 +++
 rtl/lockin_sample_fifo.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lockin_pkg.sv
`default_nettype none
// ============================================================================
// lockin_pkg : shared widths and the canonical lock-in sample record
// Rev 1.0
// ============================================================================
package lockin_pkg;

    localparam int LOCKIN_DATA_W = 24;
    localparam int SEQ_W         = 32;

    typedef struct packed {
        logic signed [LOCKIN_DATA_W-1:0] x;
        logic signed [LOCKIN_DATA_W-1:0] y;
        logic        [SEQ_W-1:0]         seq;
    } sample_t;

endpackage
`default_nettype wire

// File: rtl/lockin_fifo_mem.sv
`default_nettype none
// ============================================================================
// lockin_fifo_mem : DEPTH x W register array, one write port, async read port
// Rev 1.0
// ============================================================================
module lockin_fifo_mem
    import lockin_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = $bits(sample_t),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Storage deliberately carries no reset; validity is tracked by the level.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/lockin_sample_fifo.sv
`default_nettype none
// ============================================================================
// lockin_sample_fifo : FWFT buffer of sequence-tagged lock-in x/y results
// Optional drop counter: define LOCKIN_FIFO_DROP_CNT_EN.   Rev 1.0
// ============================================================================
module lockin_sample_fifo
    import lockin_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = LOCKIN_DATA_W,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              tick_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic              rd_i,
    input  logic              clr_ovf_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] x_o,
    output logic [DATA_W-1:0] y_o,
    output logic [SEQ_W-1:0]  seq_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              overflow_o,
    output logic [15:0]       drop_cnt_o
);

    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam logic [LVL_W-1:0]   LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]   LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
    localparam logic [SEQ_W-1:0]   SEQ_ONE  = SEQ_W'(1);

    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [SEQ_W-1:0]  seq;
    } entry_t;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             overflow_q, overflow_d;

    logic   full, empty, do_push, do_pop, drop;
    entry_t wr_entry, rd_entry;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);

    // A pop frees the slot the same cycle, so a tick on a full FIFO with rd is kept.
    assign do_pop  = rd_i & ~empty;
    assign do_push = tick_i & (~full | do_pop);
    assign drop    = tick_i & ~do_push;

    assign wr_entry = '{x: x_i, y: y_i, seq: seq_q};

    lockin_fifo_mem #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (do_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;

        if (tick_i) begin
            seq_d = seq_q + SEQ_ONE;
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_ONE;
        end else if (do_pop && !do_push) begin
            level_d = level_q - LVL_ONE;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef LOCKIN_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && clr_ovf_i) begin
            drop_cnt_d = 16'd1;
        end else if (drop) begin
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (clr_ovf_i) begin
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = '0;
`endif

    assign valid_o    = ~empty;
    assign x_o        = valid_o ? rd_entry.x   : '0;
    assign y_o        = valid_o ? rd_entry.y   : '0;
    assign seq_o      = valid_o ? rd_entry.seq : '0;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;

endmodule
`default_nettype wire
